// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the LED PWM driver: blink FSM states,
// datapath widths and the blink-limit helper.
package led_pwm_pkg;

    localparam int PWM_W   = 8;
    localparam int BLINK_W = 16;

    localparam logic [PWM_W-1:0] BR_FULL = 8'hFF;
    localparam logic [PWM_W-1:0] PWM_MAX = '1;

    typedef enum logic [1:0] {
        SOLID     = 2'd0,
        BLINK_ON  = 2'd1,
        BLINK_OFF = 2'd2
    } blink_state_e;

    // Terminal blink count: a half-period of 0 behaves like 1.
    function automatic logic [BLINK_W-1:0] blink_limit(input logic [BLINK_W-1:0] half);
        return (half == '0) ? '0 : half - 1'b1;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler and free-running PWM counter; flags each prescaler tick and the
// tick on which the PWM counter wraps (the period edge).
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = 250
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    output logic             tick,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             period_edge
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE_DIV - 1);

    logic [15:0] presc;

    assign tick        = (presc == PRESC_LAST);
    assign period_edge = tick && (pwm_cnt == PWM_MAX);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of process ordering.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Counter wraps 255 -> 0 naturally through its width.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_drv.sv
// LED pin driver: period-latched pattern/brightness PWM with a blink envelope.
// Optional breathing ramp is built when LED_PWM_BREATHE_EN is defined.
module led_pwm_drv
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = 250,
    parameter int PWM_BITS     = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [7:0]          LED_IN,
    input  logic [PWM_BITS-1:0] BRIGHTNESS,
    input  logic                BLINK_EN,
    input  logic [BLINK_W-1:0]  BLINK_HALF,
`ifdef LED_PWM_BREATHE_EN
    input  logic                BREATHE,
`endif
    output logic [7:0]          LED_OUT,
    output logic                PERIOD_END
);

    logic                tick;
    logic                tick_q;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                period_edge;

    logic [7:0]          shadow_pat;
    logic [PWM_BITS-1:0] shadow_br;
    logic [PWM_BITS-1:0] eff_br;

    blink_state_e        state_q, state_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;

    logic                pwm_on;
    logic [7:0]          led_d;

    led_pwm_timebase #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_timebase (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .tick        (tick),
        .pwm_cnt     (pwm_cnt),
        .period_edge (period_edge)
    );

    // Software-visible inputs are only accepted at period boundaries.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            shadow_pat <= '0;
            shadow_br  <= '0;
        end else if (period_edge) begin
            shadow_pat <= LED_IN;
            shadow_br  <= BRIGHTNESS;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= SOLID;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        if (period_edge) begin
            unique case (state_q)
                SOLID: begin
                    if (BLINK_EN) begin
                        state_d     = BLINK_ON;
                        blink_cnt_d = '0;
                    end
                end
                BLINK_ON, BLINK_OFF: begin
                    if (!BLINK_EN) begin
                        state_d     = SOLID;
                        blink_cnt_d = '0;
                    end else if (blink_cnt_q == blink_limit(BLINK_HALF)) begin
                        state_d     = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = SOLID;
                    blink_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [PWM_BITS-1:0] ramp_q;
    logic                ramp_up_q;

    // Triangle ramp between 0 and shadow_br, one step per period edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ramp_q    <= '0;
            ramp_up_q <= 1'b1;
        end else if (!BREATHE) begin
            ramp_q    <= '0;
            ramp_up_q <= 1'b1;
        end else if (period_edge) begin
            if (ramp_up_q) begin
                if (ramp_q >= shadow_br) begin
                    ramp_up_q <= 1'b0;
                    ramp_q    <= (shadow_br == '0) ? '0 : shadow_br - 1'b1;
                end else begin
                    ramp_q    <= ramp_q + 1'b1;
                end
            end else begin
                if (ramp_q == '0) begin
                    ramp_up_q <= 1'b1;
                    ramp_q    <= (shadow_br == '0) ? '0 : 1'b1;
                end else if (ramp_q > shadow_br) begin
                    ramp_q    <= shadow_br;
                end else begin
                    ramp_q    <= ramp_q - 1'b1;
                end
            end
        end
    end

    assign eff_br = BREATHE ? ramp_q : shadow_br;
`else
    assign eff_br = shadow_br;
`endif

    assign pwm_on = (eff_br == BR_FULL) || (pwm_cnt < eff_br);
    assign led_d  = shadow_pat & {8{pwm_on && (state_q != BLINK_OFF)}};

    // Compare inputs only move on tick edges, so the pin register refreshes
    // on the cycle after each tick rather than every cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tick_q     <= 1'b0;
            LED_OUT    <= '0;
            PERIOD_END <= 1'b0;
        end else begin
            tick_q     <= tick;
            PERIOD_END <= period_edge;
            if (tick_q) begin
                LED_OUT <= led_d;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_drv.sv
// Directed bench for led_pwm_drv: one instance at PRESCALE_DIV=2, one at 1.
module tb_led_pwm_drv;
    import led_pwm_pkg::*;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic [7:0]  LED_IN  = 8'h00;
    logic [7:0]  BRIGHTNESS = 8'h00;
    logic        BLINK_EN = 1'b0;
    logic [15:0] BLINK_HALF = 16'd0;
    logic [7:0]  led1, led2;
    logic        pe1, pe2;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    led_pwm_drv #(.PRESCALE_DIV(2), .PWM_BITS(8)) u_div2 (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .LED_IN     (LED_IN),
        .BRIGHTNESS (BRIGHTNESS),
        .BLINK_EN   (BLINK_EN),
        .BLINK_HALF (BLINK_HALF),
`ifdef LED_PWM_BREATHE_EN
        .BREATHE    (1'b0),
`endif
        .LED_OUT    (led2),
        .PERIOD_END (pe2)
    );

    led_pwm_drv #(.PRESCALE_DIV(1), .PWM_BITS(8)) u_div1 (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .LED_IN     (LED_IN),
        .BRIGHTNESS (BRIGHTNESS),
        .BLINK_EN   (BLINK_EN),
        .BLINK_HALF (BLINK_HALF),
`ifdef LED_PWM_BREATHE_EN
        .BREATHE    (1'b0),
`endif
        .LED_OUT    (led1),
        .PERIOD_END (pe1)
    );

    // Advance to the negedge following the next u_div1 period edge.
    task automatic wait_pe1();
        int n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!pe1 && n < 600);
        total++;
        if (pe1 !== 1'b1) begin
            bad++;
            $display("FAIL wait_pe1: PERIOD_END=%b after %0d cycles, want 1", pe1, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp1, exp2;
        logic       epe1, epe2;
        LED_IN     = 8'hFF;
        BRIGHTNESS = 8'hFF;
        repeat (2) @(negedge HCLK);
        total += 4;
        if (led1 !== 8'h00) begin bad++; $display("FAIL rst_led1: got %h want 00", led1); end
        if (led2 !== 8'h00) begin bad++; $display("FAIL rst_led2: got %h want 00", led2); end
        if (pe1 !== 1'b0 || pe2 !== 1'b0) begin
            bad++; $display("FAIL rst_pe: got %b%b want 00", pe1, pe2);
        end
        if (u_div1.state_q !== SOLID) begin
            bad++; $display("FAIL rst_state: got %0d want SOLID", u_div1.state_q);
        end
        HRESETn = 1'b1;
        for (int k = 1; k <= 1600; k++) begin
            @(negedge HCLK);
            exp2 = (k >= 513) ? 8'hFF : 8'h00;
            exp1 = (k >= 257) ? 8'hFF : 8'h00;
            epe2 = (k % 512 == 0);
            epe1 = (k % 256 == 0);
            total += 4;
            if (led2 !== exp2) begin bad++; $display("FAIL first_edge_led_div2 k=%0d: got %h want %h", k, led2, exp2); end
            if (pe2 !== epe2)  begin bad++; $display("FAIL period_end_div2 k=%0d: got %b want %b", k, pe2, epe2); end
            if (led1 !== exp1) begin bad++; $display("FAIL first_edge_led_div1 k=%0d: got %h want %h", k, led1, exp1); end
            if (pe1 !== epe1)  begin bad++; $display("FAIL period_end_div1 k=%0d: got %b want %b", k, pe1, epe1); end
        end
    endtask

    task automatic test_duty();
        int         highs = 0;
        logic [7:0] exp;
        LED_IN     = 8'hA5;
        BRIGHTNESS = 8'd64;
        wait_pe1();
        for (int j = 1; j <= 256; j++) begin
            @(negedge HCLK);
            exp = (j <= 64) ? 8'hA5 : 8'h00;
            if (led1 == 8'hA5) highs++;
            total += 2;
            if (led1 !== exp) begin bad++; $display("FAIL duty64 j=%0d: got %h want %h", j, led1, exp); end
            if (pe1 !== (j == 256)) begin bad++; $display("FAIL duty64_pe j=%0d: got %b", j, pe1); end
        end
        total++;
        if (highs != 64) begin bad++; $display("FAIL duty64_count: got %0d want 64", highs); end
    endtask

    task automatic test_mid_change();
        logic [7:0] exp;
        int         h0 = 0, h1 = 0;
        for (int j = 1; j <= 512; j++) begin
            @(negedge HCLK);
            if (j <= 256) exp = (j <= 64) ? 8'hA5 : 8'h00;
            else          exp = (j - 256 <= 200) ? 8'hA5 : 8'h00;
            if (led1 == 8'hA5) begin
                if (j <= 256) h0++; else h1++;
            end
            total++;
            if (led1 !== exp) begin bad++; $display("FAIL mid_change j=%0d: got %h want %h", j, led1, exp); end
            if (j == 100) BRIGHTNESS = 8'd200;
        end
        total += 2;
        if (h0 != 64)  begin bad++; $display("FAIL mid_change_cur: got %0d high want 64", h0); end
        if (h1 != 200) begin bad++; $display("FAIL mid_change_next: got %0d high want 200", h1); end
    endtask

    task automatic test_blink();
        logic       on_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp;
        LED_IN     = 8'h01;
        BRIGHTNESS = 8'hFF;
        BLINK_EN   = 1'b1;
        BLINK_HALF = 16'd2;
        wait_pe1();
        for (int p = 0; p < 5; p++) begin
            exp = on_tab[p] ? 8'h01 : 8'h00;
            for (int j = 1; j <= 256; j++) begin
                @(negedge HCLK);
                total++;
                if (led1 !== exp) begin bad++; $display("FAIL blink p=%0d j=%0d: got %h want %h", p, j, led1, exp); end
                if (p == 2 && j == 128) BLINK_EN = 1'b0;
            end
        end
    endtask

    task automatic test_half0();
        logic       on_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp;
        BLINK_EN   = 1'b1;
        BLINK_HALF = 16'd0;
        for (int p = 0; p < 5; p++) begin
            exp = on_tab[p] ? 8'h01 : 8'h00;
            for (int j = 1; j <= 256; j++) begin
                @(negedge HCLK);
                total++;
                if (led1 !== exp) begin bad++; $display("FAIL half0 p=%0d j=%0d: got %h want %h", p, j, led1, exp); end
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [7:0] exp;
        repeat (50) @(negedge HCLK);
        total += 2;
        if (u_div1.state_q !== BLINK_ON) begin bad++; $display("FAIL pre_reset_state: got %0d want BLINK_ON", u_div1.state_q); end
        if (led1 !== 8'h01) begin bad++; $display("FAIL pre_reset_led: got %h want 01", led1); end
        HRESETn = 1'b0;
        #1;
        total += 4;
        if (led1 !== 8'h00) begin bad++; $display("FAIL async_rst_led: got %h want 00", led1); end
        if (pe1 !== 1'b0 || pe2 !== 1'b0) begin bad++; $display("FAIL async_rst_pe: got %b%b want 00", pe1, pe2); end
        if (u_div1.state_q !== SOLID) begin bad++; $display("FAIL async_rst_state: got %0d want SOLID", u_div1.state_q); end
        if (u_div1.blink_cnt_q !== 16'd0) begin bad++; $display("FAIL async_rst_cnt: got %0d want 0", u_div1.blink_cnt_q); end
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            @(negedge HCLK);
            exp = (k >= 257) ? 8'h01 : 8'h00;
            total++;
            if (led1 !== exp) begin bad++; $display("FAIL post_reset k=%0d: got %h want %h", k, led1, exp); end
            if (k == 1) begin
                total++;
                if (u_div1.state_q !== SOLID) begin bad++; $display("FAIL post_reset_solid: got %0d", u_div1.state_q); end
            end
            if (k == 257) begin
                total++;
                if (u_div1.state_q !== BLINK_ON) begin bad++; $display("FAIL post_reset_blink_on: got %0d", u_div1.state_q); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_mid_change();
        test_blink();
        test_half0();
        test_reset_mid_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pwm_drv.md
Name: led_pwm_drv

Overview:
- Sits directly downstream of the AHB-lite LED register peripheral.
- Consumes its 8-bit LED pattern and drives the board LED pins with per-period latched PWM brightness and an optional blink envelope.
- Pattern and brightness changes are sampled only at PWM period boundaries, so software writes never cause mid-period glitches.

Parameters:
- PRESCALE_DIV, 250, HCLK cycles per PWM tick (legal range 1..65535).
- PWM_BITS, 8, width of the PWM counter and brightness; fixed at 8 for this release.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- LED_IN  input  8  LED pattern from the LED register; bit i enables pin i.
- BRIGHTNESS  input  8  duty control: 0 = off, 255 = fully on, else BRIGHTNESS/256.
- BLINK_EN  input  1  enables the blink envelope.
- BLINK_HALF  input  16  blink half-period in PWM periods; 0 is treated as 1.
- LED_OUT  output  8  registered LED pin drive, active high.
- PERIOD_END  output  1  one-cycle pulse per PWM period.

Behaviour:
- Reset (asynchronous, HRESETn=0):
  - Prescaler, pwm_cnt, blink_cnt, and the shadow pattern and brightness registers clear to 0.
  - State = SOLID.
  - LED_OUT = 0x00, PERIOD_END = 0.
- Prescaler:
  - presc counts 0..PRESCALE_DIV-1, then wraps.
  - tick = (presc == PRESCALE_DIV-1).
  - PRESCALE_DIV=1 gives tick on every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 255 to 0.
  - The edge on which it wraps is the "period edge".
- Period edge actions, all on the same clock edge:
  - shadow_pat <= LED_IN and shadow_br <= BRIGHTNESS.
  - BLINK_EN and BLINK_HALF are sampled.
  - The FSM advances.
  - PERIOD_END is high for the following cycle only.
- FSM states SOLID, BLINK_ON, BLINK_OFF; transitions evaluated only at the period edge:
  - SOLID: if BLINK_EN, go to BLINK_ON with blink_cnt=0.
  - BLINK_ON / BLINK_OFF: if !BLINK_EN, go to SOLID with blink_cnt=0.
  - Else if blink_cnt == max(BLINK_HALF,1)-1, toggle ON/OFF and set blink_cnt=0.
  - Else blink_cnt+1.
- Output, registered, 1-cycle latency from counter and shadows:
  - on = (shadow_br==255) | (pwm_cnt < shadow_br).
  - LED_OUT[i] <= shadow_pat[i] & on & (state != BLINK_OFF).
- Boundaries:
  - Input changes mid-period have no effect until the next period edge.
  - After reset, LED_OUT stays 0 until the first period edge loads the shadows.
  - BLINK_HALF changing mid-blink takes effect on the next comparison.
  - Reset mid-blink returns to SOLID and drives LEDs off immediately.

Optional Feature:
- Macro: LED_PWM_BREATHE_EN.
- When defined:
  - Extra input port BREATHE (1 bit) exists.
  - With BREATHE=1, effective brightness ramps by ±1 per period edge between 0 and shadow_br, starting upward from 0.
  - Direction reverses at each end, and the ramp replaces shadow_br in the compare.
  - BREATHE=0 resets the ramp to 0 and uses shadow_br directly.
- When undefined: no BREATHE port and no ramp logic; behaviour is exactly as above.

Decomposition:
- Package led_pwm_pkg holds:
  - FSM state enum (SOLID, BLINK_ON, BLINK_OFF).
  - PWM_W=8 and BLINK_W=16 width constants.
  - BR_FULL=8'hFF.
- One natural sub-module, led_pwm_timebase (prescaler + pwm_cnt), producing tick, pwm_cnt and the period-edge strobe.
- FSM, shadows and output compare stay in the top level.

Test Plan:
- Reset release with LED_IN=0xFF, BRIGHTNESS=255, PRESCALE_DIV=2 -> LED_OUT=0x00 until the first period edge (cycle 512), then 0xFF continuously; PERIOD_END pulses every 512 cycles.
- LED_IN=0xA5, BRIGHTNESS=64, PRESCALE_DIV=1 -> per 256-cycle period, LED_OUT=0xA5 for exactly 64 cycles, then 0x00 for 192 cycles.
- BRIGHTNESS changes 64 to 200 at pwm_cnt=100 -> current period keeps duty 64; the next period shows 200 high cycles.
- BLINK_EN=1, BLINK_HALF=2, BRIGHTNESS=255, LED_IN=0x01 -> 2 periods on, 2 off, repeating; BLINK_EN=0 during OFF -> SOLID and on from the next period edge.
- BLINK_HALF=0 with BLINK_EN=1 -> toggles every period, identical to BLINK_HALF=1.
- HRESETn asserted mid-period while in BLINK_ON -> LED_OUT=0x00 and PERIOD_END=0 immediately; state SOLID after release.
